// File: rtl/mips_io_ctrl_if.sv
// CPU-side request bus for the MIPS memory-mapped I/O responder.
// The master drives requests; the slave returns read data.
interface mips_io_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        io_addr;
  logic              io_rd;
  logic              io_wr;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic              io_rvalid;

  modport master (
    output io_addr, io_rd, io_wr, io_wdata,
    input  io_rdata, io_rvalid
  );

  modport slave (
    input  io_addr, io_rd, io_wr, io_wdata,
    output io_rdata, io_rvalid
  );
endinterface

// File: rtl/mips_io_ctrl.sv
// MIPS memory-mapped I/O: two captured input ports, LEDs, sticky status.
// Optional macro MIPS_IO_IRQ_EN adds a maskable io_irq output.
module mips_io_ctrl #(
  parameter int DATA_W      = 32,
  parameter int LED_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              port_sel,
  input  logic              port_en,
  input  logic [DATA_W-1:0] user_input,
  mips_io_ctrl_if.slave     bus,
  output logic [LED_W-1:0]  leds
`ifdef MIPS_IO_IRQ_EN
  ,
  output logic              io_irq
`endif
);

  logic [SYNC_STAGES-1:0] en_sync;
  logic [SYNC_STAGES-1:0] sel_sync;
  logic                   en_prev;
  logic                   en_s;
  logic                   sel_s;
  logic                   cap;
  logic                   cap0;
  logic                   cap1;

  logic [DATA_W-1:0] inport0;
  logic [DATA_W-1:0] inport1;
  logic              new0;
  logic              new1;
  logic              ovr;

  logic              rd0;
  logic              rd1;
  logic              rd_st;
  logic              wr_led;
  logic [DATA_W-1:0] led_ext;
  logic [DATA_W-1:0] st_ext;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_bits;

  assign en_s  = en_sync[SYNC_STAGES-1];
  assign sel_s = sel_sync[SYNC_STAGES-1];
  assign cap   = en_s & ~en_prev;
  assign cap0  = cap & ~sel_s;
  assign cap1  = cap & sel_s;

  assign rd0    = bus.io_rd & (bus.io_addr == 2'd0);
  assign rd1    = bus.io_rd & (bus.io_addr == 2'd1);
  assign rd_st  = bus.io_rd & (bus.io_addr == 2'd3);
  assign wr_led = bus.io_wr & (bus.io_addr == 2'd2);

  // Upper write-data bits have no destination.
  assign unused_bits = ^bus.io_wdata;

  // Board inputs cross into clk; previous en kept for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sync  <= '0;
      sel_sync <= '0;
      en_prev  <= 1'b0;
    end else begin
      en_sync  <= {en_sync[SYNC_STAGES-2:0], port_en};
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], port_sel};
      en_prev  <= en_s;
    end
  end

  // Capture user_input into the selected input port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inport0 <= '0;
      inport1 <= '0;
    end else begin
      if (cap0) inport0 <= user_input;
      if (cap1) inport1 <= user_input;
    end
  end

  // Sticky status: capture sets win over read clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      new0 <= 1'b0;
      new1 <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      new0 <= cap0 | (new0 & ~rd0);
      new1 <= cap1 | (new1 & ~rd1);
      ovr  <= (cap0 & new0) | (cap1 & new1) | (ovr & ~rd_st);
    end
  end

  // LED register, written from the CPU bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds <= '0;
    end else if (wr_led) begin
      leds <= bus.io_wdata[LED_W-1:0];
    end
  end

  // Zero-extended views of LEDS and STATUS for the read mux.
  always_comb begin
    led_ext             = '0;
    led_ext[LED_W-1:0]  = leds;
    st_ext              = '0;
    st_ext[2:0]         = {ovr, new1, new0};
  end

  // Read mux sees pre-update register values.
  always_comb begin
    rd_mux = '0;
    unique case (bus.io_addr)
      2'd0: rd_mux = inport0;
      2'd1: rd_mux = inport1;
      2'd2: rd_mux = led_ext;
      2'd3: rd_mux = st_ext;
      default: rd_mux = '0;
    endcase
  end

  // Registered read response, one cycle after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.io_rdata  <= '0;
      bus.io_rvalid <= 1'b0;
    end else begin
      bus.io_rvalid <= bus.io_rd;
      if (bus.io_rd) bus.io_rdata <= rd_mux;
    end
  end

`ifdef MIPS_IO_IRQ_EN
  logic mask;
  logic wr_st;

  assign wr_st = bus.io_wr & (bus.io_addr == 2'd3);

  // Interrupt mask and registered interrupt from pending NEW bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask   <= 1'b0;
      io_irq <= 1'b0;
    end else begin
      if (wr_st) mask <= bus.io_wdata[0];
      io_irq <= (new0 | new1) & ~mask;
    end
  end
`endif

endmodule

// File: tb/tb_mips_io_ctrl.sv
// Scoreboard bench for mips_io_ctrl.
// Reads push expectations; a negedge monitor pops on io_rvalid.
module tb_mips_io_ctrl;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        port_sel;
  logic        port_en;
  logic [31:0] user_input;
  logic [15:0] leds;
`ifdef MIPS_IO_IRQ_EN
  logic        io_irq;
`endif

  int   cyc;
  int   total;
  int   passed;
  exp_t sbq[$];

  mips_io_ctrl_if #(.DATA_W(32)) bus ();

  mips_io_ctrl #(
    .DATA_W(32),
    .LED_W(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .port_sel(port_sel),
    .port_en(port_en),
    .user_input(user_input),
    .bus(bus),
    .leds(leds)
`ifdef MIPS_IO_IRQ_EN
    ,
    .io_irq(io_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Monitor: compare every read response against the scoreboard.
  always @(negedge clk) begin
    if (bus.io_rvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_rvalid: got data %h with no read pending",
                 bus.io_rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk(e.name, bus.io_rdata, e.data);
        chk({e.name, "_lat"}, cyc, e.cyc);
      end
    end
  end

  task automatic rd(input logic [1:0] a, input logic [31:0] e,
                    input string n);
    @(negedge clk);
    bus.io_addr = a;
    bus.io_rd   = 1'b1;
    sbq.push_back('{e, cyc + 1, n});
    @(negedge clk);
    bus.io_rd = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.io_addr  = a;
    bus.io_wdata = d;
    bus.io_wr    = 1'b1;
    @(negedge clk);
    bus.io_wr = 1'b0;
  endtask

  task automatic capture(input logic s, input logic [31:0] d);
    @(negedge clk);
    port_sel   = s;
    user_input = d;
    port_en    = 1'b1;
    repeat (3) @(negedge clk);
    port_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc          = 0;
    total        = 0;
    passed       = 0;
    rst          = 1'b0;
    port_sel     = 1'b0;
    port_en      = 1'b0;
    user_input   = '0;
    bus.io_addr  = '0;
    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    bus.io_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_leds", {16'h0, leds}, 32'h0);
    chk("rst_rvalid", {31'h0, bus.io_rvalid}, 32'h0);
    rst = 1'b1;

    rd(2'd0, 32'h0, "rst_in0");
    rd(2'd1, 32'h0, "rst_in1");
    rd(2'd2, 32'h0, "rst_led");
    rd(2'd3, 32'h0, "rst_st");

    wr(2'd2, 32'hFFFFA5A5);
    chk("led_wr", {16'h0, leds}, 32'h0000A5A5);
    rd(2'd2, 32'h0000A5A5, "led_rd");
    wr(2'd0, 32'h00001111);
    rd(2'd0, 32'h0, "in0_wr_ignored");
    wr(2'd3, 32'hFFFFFFF8);
    rd(2'd3, 32'h0, "st_wr_ignored");

    wr(2'd2, 32'h000000FF);
    chk("led_ff", {16'h0, leds}, 32'h000000FF);
    @(negedge clk);
    bus.io_addr = 2'd2;
    bus.io_rd   = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_leds", {16'h0, leds}, 32'h0);
    @(negedge clk);
    bus.io_rd = 1'b0;
    chk("mid_rst_rvalid", {31'h0, bus.io_rvalid}, 32'h0);
`ifdef MIPS_IO_IRQ_EN
    chk("mid_rst_irq", {31'h0, io_irq}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    rd(2'd0, 32'h0, "post_rst_in0");
    rd(2'd1, 32'h0, "post_rst_in1");
    rd(2'd2, 32'h0, "post_rst_led");
    rd(2'd3, 32'h0, "post_rst_st");

    capture(1'b0, 32'h0000CAFE);
`ifdef MIPS_IO_IRQ_EN
    chk("irq_set", {31'h0, io_irq}, 32'h1);
    wr(2'd3, 32'h1);
    @(negedge clk);
    chk("irq_masked", {31'h0, io_irq}, 32'h0);
    wr(2'd3, 32'h0);
    @(negedge clk);
    chk("irq_unmasked", {31'h0, io_irq}, 32'h1);
`endif
    rd(2'd3, 32'h1, "cap0_st");
    rd(2'd0, 32'h0000CAFE, "cap0_in0");
`ifdef MIPS_IO_IRQ_EN
    @(negedge clk);
    chk("irq_cleared", {31'h0, io_irq}, 32'h0);
`endif
    rd(2'd3, 32'h0, "cap0_st_clr");

    capture(1'b1, 32'h12345678);
    capture(1'b1, 32'hDEADBEEF);
    rd(2'd3, 32'h6, "ovr_st");
    rd(2'd3, 32'h2, "ovr_st2");
    rd(2'd1, 32'hDEADBEEF, "ovr_in1");
    rd(2'd3, 32'h0, "ovr_st_clr");

    @(negedge clk);
    port_sel   = 1'b0;
    user_input = 32'hBEEF0001;
    port_en    = 1'b1;
    repeat (2) @(negedge clk);
    bus.io_addr = 2'd0;
    bus.io_rd   = 1'b1;
    sbq.push_back('{32'h0000CAFE, cyc + 1, "coll_old"});
    @(negedge clk);
    bus.io_rd = 1'b0;
    @(negedge clk);
    port_en = 1'b0;
    repeat (3) @(negedge clk);
    rd(2'd3, 32'h1, "coll_st");
    rd(2'd0, 32'hBEEF0001, "coll_new");
    rd(2'd3, 32'h0, "coll_st_clr");

    @(negedge clk);
    bus.io_addr  = 2'd2;
    bus.io_wdata = 32'h00001234;
    bus.io_wr    = 1'b1;
    bus.io_rd    = 1'b1;
    sbq.push_back('{32'h0, cyc + 1, "rdwr_old"});
    @(negedge clk);
    bus.io_wr = 1'b0;
    bus.io_rd = 1'b0;
    chk("rdwr_leds", {16'h0, leds}, 32'h00001234);
    rd(2'd2, 32'h00001234, "rdwr_new");

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_io_ctrl.md
Name: mips_io_ctrl

Overview:
- Memory-mapped I/O responder between the MIPS datapath's load/store path and the board-level user ports.
- Captures `user_input` into one of two input port registers when `port_en` is pulsed; `port_sel` picks the port.
- Holds the LED output register and a sticky status register. The CPU reads and writes all of them through a simple single-cycle request bus.

Parameters:
- DATA_W, 32, width of `user_input`, input port registers and bus data.
- LED_W, 16, width of the LED output register; must be ≤ DATA_W.
- SYNC_STAGES, 2, synchronizer depth for the `port_en` and `port_sel` board inputs; minimum 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk.
- port_sel  input  1  board input: 0 selects INPORT0, 1 selects INPORT1.
- port_en  input  1  board input: a rising edge requests capture of `user_input`.
- user_input  input  DATA_W  board data value, held stable while `port_en` is high.
- io_addr  input  2  register index: 0=INPORT0, 1=INPORT1, 2=LEDS, 3=STATUS.
- io_rd  input  1  CPU read request, single-cycle strobe.
- io_wr  input  1  CPU write request, single-cycle strobe.
- io_wdata  input  DATA_W  CPU write data.
- io_rdata  output  DATA_W  read data, valid when `io_rvalid` is 1.
- io_rvalid  output  1  one-cycle pulse, one clk after the accepted `io_rd`.
- leds  output  LED_W  LED register value.

Behaviour:
- Reset (rst=0, asynchronous):
  - INPORT0, INPORT1, LEDS, STATUS, `io_rdata` and synchronizer flops all go to 0.
  - `io_rvalid` goes to 0.
- Synchronization and edge detection:
  - `port_en` and `port_sel` each pass through SYNC_STAGES flops.
  - A rising edge of synchronized `port_en` (previous 0, current 1) produces a one-cycle `cap` pulse.
  - `user_input` is sampled unsynchronized on the `cap` cycle; board data is quasi-static.
- Capture:
  - On `cap`, INPORT[sel_sync] <= `user_input`, and STATUS bit sel_sync (NEW0/NEW1) is set.
  - Latency: `port_en` rise to register update is SYNC_STAGES+1 clk edges.
  - A held-high `port_en` produces exactly one capture. Repeated pulses overwrite the register.
  - If the NEW bit is already set on a capture, STATUS bit 2 (OVR) is also set.
- Read:
  - `io_rd` at cycle N: `io_rdata` = selected register at cycle N+1, with `io_rvalid`=1 for one cycle.
  - With no read, `io_rdata` holds its last value and `io_rvalid`=0.
  - STATUS layout: bit0 NEW0, bit1 NEW1, bit2 OVR, other bits 0.
  - Reading INPORT0 clears NEW0; reading INPORT1 clears NEW1; reading STATUS clears OVR.
  - Reading LEDS returns the LED register zero-extended to DATA_W.
- Write:
  - `io_wr` with io_addr=2: LEDS <= io_wdata[LED_W-1:0], visible on `leds` on the next edge.
  - Writes to addresses 0, 1 and 3 are ignored; no side effects.
- Simultaneous events:
  - `io_rd` and `io_wr` in the same cycle: both are performed. A read of LEDS returns the pre-write value.
  - `cap` and a read of the same INPORT in the same cycle: `io_rdata` returns the old value, the register takes the new value, and the NEW bit ends at 1 (set wins over clear).
  - `cap` and a STATUS read in the same cycle: OVR set wins over clear.
- Reset mid-operation: a pending `io_rvalid` is dropped and all state returns to reset values immediately.

Optional Feature:
- Macro: MIPS_IO_IRQ_EN.
- When defined:
  - Adds output port `io_irq` (1 bit), registered, reset 0.
  - `io_irq` = NEW0 | NEW1, updated one clk after the STATUS change.
  - Adds register index 3 write support: io_wdata bit0 = 1 masks the irq (mask reset 0). `io_irq` = (NEW0|NEW1) & ~mask.
- When undefined: no `io_irq` port, no mask register, and STATUS writes are ignored.

Test Plan:
- Reset: drive rst=0 mid-run after LEDS=16'h00FF → `leds`=0, `io_rvalid`=0, and all reads return 0 after rst=1.
- Capture on INPORT0:
  - Stimulus: port_sel=0, user_input=32'h0000CAFE, pulse port_en for 3 clk.
  - Response: exactly one capture. A STATUS read returns 32'h1, then an INPORT0 read returns 32'h0000CAFE with `io_rvalid` one cycle after `io_rd`, then a STATUS read returns 0.
- Overrun on INPORT1:
  - Stimulus: port_sel=1, capture 32'h12345678, then capture 32'hDEADBEEF without reading.
  - Response: STATUS=32'h6, INPORT1=32'hDEADBEEF, and a second STATUS read returns 32'h2.
- LED write: io_wr to addr 2 with io_wdata=32'hFFFFA5A5 → `leds`=16'hA5A5 next edge. A read of addr 2 returns 32'h0000A5A5; writes to addr 0 leave INPORT0 unchanged.
- Collision: `cap` coincides with an INPORT0 read → `io_rdata` = old value, INPORT0 = new value, NEW0 stays 1.
- MIPS_IO_IRQ_EN: a capture asserts `io_irq`; writing 1 to addr 3 deasserts it; unmasking then reading INPORT0 deasserts it.
